// File: rtl/jpeg_dc_pkg.sv
// Shared definitions for the JPEG baseline DC Huffman decoder: the DC SIZE
// prefix-code tables for luminance and chrominance, code-length limits and
// the decoder state encoding.
package jpeg_dc_pkg;

    localparam int SIZE_W           = 4;
    localparam int CODE_W           = 11;
    localparam int MAX_CODE_LEN     = 11;
    localparam int LUM_MAX_CODE_LEN = 9;
    localparam int NUM_SIZES        = 12;

    typedef enum logic [1:0] {
        CODE,
        MAG,
        OUT
    } dc_state_e;

    // Right-aligned prefix code for a SIZE category in the selected table.
    function automatic logic [CODE_W-1:0] dcCode(input logic isLum, input logic [SIZE_W-1:0] size);
        logic [CODE_W-1:0] code;
        code = '0;
        if (isLum) begin
            case (size)
                4'd0:    code = 11'b00;
                4'd1:    code = 11'b010;
                4'd2:    code = 11'b011;
                4'd3:    code = 11'b100;
                4'd4:    code = 11'b101;
                4'd5:    code = 11'b110;
                4'd6:    code = 11'b1110;
                4'd7:    code = 11'b11110;
                4'd8:    code = 11'b111110;
                4'd9:    code = 11'b1111110;
                4'd10:   code = 11'b11111110;
                4'd11:   code = 11'b111111110;
                default: code = '0;
            endcase
        end else begin
            case (size)
                4'd0:    code = 11'b00;
                4'd1:    code = 11'b01;
                4'd2:    code = 11'b10;
                4'd3:    code = 11'b110;
                4'd4:    code = 11'b1110;
                4'd5:    code = 11'b11110;
                4'd6:    code = 11'b111110;
                4'd7:    code = 11'b1111110;
                4'd8:    code = 11'b11111110;
                4'd9:    code = 11'b111111110;
                4'd10:   code = 11'b1111111110;
                4'd11:   code = 11'b11111111110;
                default: code = '0;
            endcase
        end
        return code;
    endfunction

    // Length in bits of the prefix code for a SIZE category.
    function automatic logic [SIZE_W-1:0] dcCodeLen(input logic isLum, input logic [SIZE_W-1:0] size);
        logic [SIZE_W-1:0] len;
        len = '0;
        if (isLum) begin
            case (size)
                4'd0:                      len = 4'd2;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5: len = 4'd3;
                4'd6:                      len = 4'd4;
                4'd7:                      len = 4'd5;
                4'd8:                      len = 4'd6;
                4'd9:                      len = 4'd7;
                4'd10:                     len = 4'd8;
                4'd11:                     len = 4'd9;
                default:                   len = '0;
            endcase
        end else begin
            if (size <= 4'd2) begin
                len = 4'd2;
            end else if (size <= 4'd11) begin
                len = size;
            end else begin
                len = '0;
            end
        end
        return len;
    endfunction

    // Mask selecting the low 'len' bits of a code word.
    function automatic logic [CODE_W-1:0] lenMask(input logic [SIZE_W-1:0] len);
        logic [CODE_W:0] wide;
        wide = ({{CODE_W{1'b0}}, 1'b1} << len) - {{CODE_W{1'b0}}, 1'b1};
        return wide[CODE_W-1:0];
    endfunction

endpackage

// File: rtl/huff_dc_code_match.sv
// Combinational DC SIZE prefix-code matcher. Given the bits collected so far
// (right-aligned) and their count, reports whether they form a complete code
// of the selected table and which SIZE category it encodes.
module huff_dc_code_match
    import jpeg_dc_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic [SIZE_W-1:0] len_i,
    input  logic              is_lum_i,
    output logic              hit_o,
    output logic [SIZE_W-1:0] size_o
);

    // Scan every SIZE entry; the tables are prefix-free so at most one hits.
    always_comb begin
        hit_o  = 1'b0;
        size_o = '0;
        for (int s = 0; s < NUM_SIZES; s++) begin
            if (!hit_o
                && (len_i == dcCodeLen(is_lum_i, SIZE_W'(s)))
                && ((code_i & lenMask(len_i)) == dcCode(is_lum_i, SIZE_W'(s)))) begin
                hit_o  = 1'b1;
                size_o = SIZE_W'(s);
            end
        end
    end

endmodule

// File: rtl/huffman_dc_dec.sv
// Bit-serial JPEG baseline DC decoder. Accepts an MSB-first entropy-coded
// stream one bit per handshake, matches the DC SIZE prefix code, collects
// SIZE magnitude bits and presents the signed DC difference.
// Build option: define DC_PRED_EN to keep per-component DC predictors and
// output the reconstructed DC value instead of the raw difference.
module huffman_dc_dec #(
    parameter int DC_W         = 12,
    parameter int MAX_CODE_LEN = jpeg_dc_pkg::MAX_CODE_LEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            is_luminance,
    input  logic            bit_valid,
    output logic            bit_ready,
    input  logic            bit_in,
    input  logic            pred_clr,
    output logic            dc_valid,
    input  logic            dc_ready,
    output logic [DC_W-1:0] dc_value,
    output logic [3:0]      dc_size,
    output logic            dc_err
);

    import jpeg_dc_pkg::*;

    dc_state_e           state_q,  state_d;
    logic [CODE_W-2:0]   code_q,   code_d;
    logic [SIZE_W-1:0]   len_q,    len_d;
    logic                lum_q,    lum_d;
    logic [CODE_W-2:0]   mag_q,    mag_d;
    logic [SIZE_W-1:0]   magCnt_q, magCnt_d;
    logic [SIZE_W-1:0]   size_q,   size_d;
    logic [DC_W-1:0]     diff_q,   diff_d;
    logic                err_q,    err_d;

    logic                bitFire;
    logic                resFire;
    logic                tableSel;
    logic [CODE_W-1:0]   codeNext;
    logic [SIZE_W-1:0]   lenNext;
    logic [SIZE_W-1:0]   lenLimit;
    logic                matchHit;
    logic [SIZE_W-1:0]   matchSize;
    logic [CODE_W-1:0]   magNext;
    logic [DC_W-1:0]     magExt;
    logic [DC_W-1:0]     onesMask;
    logic                magMsb;
    logic [DC_W-1:0]     diffValue;

    assign bit_ready = (state_q != OUT);
    assign dc_valid  = (state_q == OUT);
    assign dc_size   = size_q;
    assign dc_err    = err_q;

    assign bitFire = bit_valid && bit_ready;
    assign resFire = dc_valid && dc_ready;

    // The table is captured with the first code bit, so later changes of
    // is_luminance inside the same symbol have no effect.
    assign tableSel = (len_q == '0) ? is_luminance : lum_q;
    assign codeNext = {code_q, bit_in};
    assign lenNext  = len_q + SIZE_W'(1);
    assign lenLimit = tableSel ? SIZE_W'(LUM_MAX_CODE_LEN) : SIZE_W'(MAX_CODE_LEN);

    huff_dc_code_match u_match (
        .code_i   (codeNext),
        .len_i    (lenNext),
        .is_lum_i (tableSel),
        .hit_o    (matchHit),
        .size_o   (matchSize)
    );

    // A magnitude with MSB 0 encodes a negative value: mag - (2^size - 1).
    assign magNext   = {mag_q, bit_in};
    assign magExt    = DC_W'(magNext);
    assign onesMask  = (DC_W'(1) << size_q) - DC_W'(1);
    assign magMsb    = magNext[size_q - SIZE_W'(1)];
    assign diffValue = magMsb ? magExt : (magExt - onesMask);

    // Decoder state machine: prefix match, magnitude collection, result hold.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        len_d    = len_q;
        lum_d    = lum_q;
        mag_d    = mag_q;
        magCnt_d = magCnt_q;
        size_d   = size_q;
        diff_d   = diff_q;
        err_d    = err_q;
        case (state_q)
            CODE: begin
                if (bitFire) begin
                    code_d = codeNext[CODE_W-2:0];
                    len_d  = lenNext;
                    lum_d  = tableSel;
                    if (matchHit) begin
                        size_d = matchSize;
                        err_d  = 1'b0;
                        if (matchSize == '0) begin
                            diff_d  = '0;
                            state_d = OUT;
                        end else begin
                            mag_d    = '0;
                            magCnt_d = matchSize;
                            state_d  = MAG;
                        end
                    end else if (lenNext >= lenLimit) begin
                        size_d  = '0;
                        diff_d  = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end
                end
            end
            MAG: begin
                if (bitFire) begin
                    mag_d    = magNext[CODE_W-2:0];
                    magCnt_d = magCnt_q - SIZE_W'(1);
                    if (magCnt_q == SIZE_W'(1)) begin
                        diff_d  = diffValue;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (resFire) begin
                    code_d  = '0;
                    len_d   = '0;
                    state_d = CODE;
                end
            end
            default: begin
                state_d = CODE;
            end
        endcase
    end

    // Decoder registers; reset discards any partial symbol immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CODE;
            code_q   <= '0;
            len_q    <= '0;
            lum_q    <= 1'b0;
            mag_q    <= '0;
            magCnt_q <= '0;
            size_q   <= '0;
            diff_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            len_q    <= len_d;
            lum_q    <= lum_d;
            mag_q    <= mag_d;
            magCnt_q <= magCnt_d;
            size_q   <= size_d;
            diff_q   <= diff_d;
            err_q    <= err_d;
        end
    end

`ifdef DC_PRED_EN
    logic [DC_W-1:0] predLum_q, predLum_d;
    logic [DC_W-1:0] predChr_q, predChr_d;
    logic [DC_W-1:0] predSel;

    assign predSel  = lum_q ? predLum_q : predChr_q;
    assign dc_value = err_q ? '0 : (predSel + diff_q);

    // Predictor update on a good result transfer; a restart clear wins.
    always_comb begin
        predLum_d = predLum_q;
        predChr_d = predChr_q;
        if (pred_clr) begin
            predLum_d = '0;
            predChr_d = '0;
        end else if (resFire && !err_q) begin
            if (lum_q) begin
                predLum_d = predLum_q + diff_q;
            end else begin
                predChr_d = predChr_q + diff_q;
            end
        end
    end

    // Predictor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predLum_q <= '0;
            predChr_q <= '0;
        end else begin
            predLum_q <= predLum_d;
            predChr_q <= predChr_d;
        end
    end
`else
    logic unusedPredClr;

    assign unusedPredClr = pred_clr;
    assign dc_value      = diff_q;
`endif

endmodule

// File: tb/tb_huffman_dc_dec.sv
// Directed testbench for huffman_dc_dec: hand-computed DC decodes for both
// tables, error codes, back-pressure, input gaps, reset and (with
// DC_PRED_EN) predictor behaviour.
module tb_huffman_dc_dec;

    logic        clk;
    logic        rst_n;
    logic        is_luminance;
    logic        bit_valid;
    logic        bit_ready;
    logic        bit_in;
    logic        pred_clr;
    logic        dc_valid;
    logic        dc_ready;
    logic [11:0] dc_value;
    logic [3:0]  dc_size;
    logic        dc_err;

    int checks;
    int fails;
    int predLumM;
    int predChrM;

    huffman_dc_dec #(
        .DC_W         (12),
        .MAX_CODE_LEN (11)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_luminance (is_luminance),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_in       (bit_in),
        .pred_clr     (pred_clr),
        .dc_valid     (dc_valid),
        .dc_ready     (dc_ready),
        .dc_value     (dc_value),
        .dc_size      (dc_size),
        .dc_err       (dc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int expOut(input bit isLum, input int diff, input bit err);
        int r;
        logic [11:0] w;
        r = err ? 0 : diff;
        w = '0;
`ifdef DC_PRED_EN
        if (!err) begin
            w = 12'(isLum ? (predLumM + diff) : (predChrM + diff));
            r = int'($signed(w));
        end
`endif
        return r;
    endfunction

    // Sends n bits MSB-first; optionally inserts random idle gaps and flips
    // the table select after the first bit.
    task automatic applyStimulus(input logic [31:0] bits, input int n, input bit lum,
                                 input bit gaps, input bit flip);
        is_luminance = lum;
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) begin
                int idle;
                idle = int'($urandom_range(0, 2));
                for (int g = 0; g < idle; g++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            checkOutput("bitReady", int'(bit_ready), 1);
            @(posedge clk);
            #1;
            if (flip && i == n - 1) begin
                is_luminance = ~lum;
            end
            if (i == 1) begin
                checkOutput("earlyValid", int'(dc_valid), 0);
            end
        end
        bit_valid = 1'b0;
    endtask

    // Checks the held result, then accepts it (optionally with pred_clr).
    task automatic checkResult(input string tag, input bit isLum, input int expSize,
                               input int expDiff, input bit expErr, input bit clrWithAccept);
        int want;
        want = expOut(isLum, expDiff, expErr);
        checkOutput({tag, ".valid"}, int'(dc_valid), 1);
        checkOutput({tag, ".bitReady"}, int'(bit_ready), 0);
        checkOutput({tag, ".size"}, int'(dc_size), expSize);
        checkOutput({tag, ".value"}, int'($signed(dc_value)), want);
        checkOutput({tag, ".err"}, int'(dc_err), int'(expErr));
        dc_ready = 1'b1;
        pred_clr = clrWithAccept;
        @(posedge clk);
        #1;
        dc_ready = 1'b0;
        pred_clr = 1'b0;
`ifdef DC_PRED_EN
        if (clrWithAccept) begin
            predLumM = 0;
            predChrM = 0;
        end else if (!expErr) begin
            if (isLum) predLumM = want;
            else       predChrM = want;
        end
`endif
        checkOutput({tag, ".drop"}, int'(dc_valid), 0);
    endtask

    task automatic pulsePredClr();
        pred_clr = 1'b1;
        @(posedge clk);
        #1;
        pred_clr = 1'b0;
        predLumM = 0;
        predChrM = 0;
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        predLumM     = 0;
        predChrM     = 0;
        rst_n        = 1'b0;
        is_luminance = 1'b1;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        pred_clr     = 1'b0;
        dc_ready     = 1'b0;

        #3;
        checkOutput("rst.bitReady", int'(bit_ready), 1);
        checkOutput("rst.valid", int'(dc_valid), 0);
        checkOutput("rst.value", int'(dc_value), 0);
        checkOutput("rst.size", int'(dc_size), 0);
        checkOutput("rst.err", int'(dc_err), 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Luminance and chrominance decodes, both signs, size extremes.
        applyStimulus(32'b100101, 6, 1'b1, 1'b0, 1'b0);
        checkResult("lumP5", 1'b1, 3, 5, 1'b0, 1'b0);
        applyStimulus(32'b100010, 6, 1'b1, 1'b0, 1'b0);
        checkResult("lumM5", 1'b1, 3, -5, 1'b0, 1'b0);
        applyStimulus(32'b00, 2, 1'b0, 1'b0, 1'b0);
        checkResult("chrZero", 1'b0, 0, 0, 1'b0, 1'b0);
        applyStimulus(32'b1111111111010000000000, 22, 1'b0, 1'b0, 1'b0);
        checkResult("chrP1024", 1'b0, 11, 1024, 1'b0, 1'b0);
        applyStimulus(32'b1111111111000000000000, 22, 1'b0, 1'b0, 1'b0);
        checkResult("chrM2047", 1'b0, 11, -2047, 1'b0, 1'b0);
        applyStimulus(32'b011, 3, 1'b0, 1'b0, 1'b0);
        checkResult("chrP1", 1'b0, 1, 1, 1'b0, 1'b0);
        applyStimulus(32'b010, 3, 1'b0, 1'b0, 1'b0);
        checkResult("chrM1", 1'b0, 1, -1, 1'b0, 1'b0);
        applyStimulus(32'b11010011, 8, 1'b1, 1'b0, 1'b0);
        checkResult("lumP19", 1'b1, 5, 19, 1'b0, 1'b0);
        applyStimulus(32'b1110000001, 10, 1'b1, 1'b0, 1'b0);
        checkResult("lumM62", 1'b1, 6, -62, 1'b0, 1'b0);

        // Illegal luminance code, then clean recovery.
        applyStimulus(32'b111111111, 9, 1'b1, 1'b0, 1'b0);
        checkResult("lumErr", 1'b1, 0, 0, 1'b1, 1'b0);
        applyStimulus(32'b00, 2, 1'b1, 1'b0, 1'b0);
        checkResult("lumAfterErr", 1'b1, 0, 0, 1'b0, 1'b0);

        // Table select change after the first bit is ignored.
        applyStimulus(32'b100101, 6, 1'b1, 1'b0, 1'b1);
        checkResult("lumFlip", 1'b1, 3, 5, 1'b0, 1'b0);

        // Random input gaps give the same results.
        applyStimulus(32'b100101, 6, 1'b1, 1'b1, 1'b0);
        checkResult("gapP5", 1'b1, 3, 5, 1'b0, 1'b0);
        applyStimulus(32'b100010, 6, 1'b1, 1'b1, 1'b0);
        checkResult("gapM5", 1'b1, 3, -5, 1'b0, 1'b0);
        applyStimulus(32'b1111111111000000000000, 22, 1'b0, 1'b1, 1'b0);
        checkResult("gapM2047", 1'b0, 11, -2047, 1'b0, 1'b0);

        // Back-pressure: result held while dc_ready is low, bits refused.
        applyStimulus(32'b100101, 6, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold.bitReady", int'(bit_ready), 0);
            checkOutput("hold.valid", int'(dc_valid), 1);
            checkOutput("hold.size", int'(dc_size), 3);
            checkOutput("hold.value", int'($signed(dc_value)), expOut(1'b1, 5, 1'b0));
        end
        bit_valid = 1'b0;
        checkResult("holdP5", 1'b1, 3, 5, 1'b0, 1'b0);

        // Reset in the middle of a symbol discards it.
        applyStimulus(32'b10, 2, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("midRst.valid", int'(dc_valid), 0);
        checkOutput("midRst.bitReady", int'(bit_ready), 1);
        checkOutput("midRst.size", int'(dc_size), 0);
        #2;
        rst_n    = 1'b1;
        predLumM = 0;
        predChrM = 0;
        @(posedge clk);
        #1;
        applyStimulus(32'b0101, 4, 1'b1, 1'b0, 1'b0);
        checkResult("afterRst", 1'b1, 1, 1, 1'b0, 1'b0);

`ifdef DC_PRED_EN
        // Predictor accumulation, clear, and component independence.
        pulsePredClr();
        applyStimulus(32'b100101, 6, 1'b1, 1'b0, 1'b0);
        checkOutput("pred.first", int'($signed(dc_value)), 5);
        checkResult("predP5", 1'b1, 3, 5, 1'b0, 1'b0);
        applyStimulus(32'b01100, 5, 1'b1, 1'b0, 1'b0);
        checkOutput("pred.second", int'($signed(dc_value)), 2);
        checkResult("predM3", 1'b1, 2, -3, 1'b0, 1'b0);
        pulsePredClr();
        applyStimulus(32'b0101, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("pred.afterClr", int'($signed(dc_value)), 1);
        checkResult("predClrP1", 1'b1, 1, 1, 1'b0, 1'b0);
        applyStimulus(32'b110111, 6, 1'b0, 1'b0, 1'b0);
        checkOutput("pred.chr", int'($signed(dc_value)), 7);
        checkResult("predChrP7", 1'b0, 3, 7, 1'b0, 1'b0);
        applyStimulus(32'b0101, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("pred.lumKeep", int'($signed(dc_value)), 2);
        checkResult("predLumP1", 1'b1, 1, 1, 1'b0, 1'b0);
        applyStimulus(32'b100101, 6, 1'b1, 1'b0, 1'b0);
        checkResult("predClrWins", 1'b1, 3, 5, 1'b0, 1'b1);
        applyStimulus(32'b0101, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("pred.clrWon", int'($signed(dc_value)), 1);
        checkResult("predAfterWin", 1'b1, 1, 1, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
